// File: rtl/ahb_slave_wbuf.sv
// ahb_slave_wbuf: AHB-Lite slave with a posted-write FIFO in front of an
// external memory/peripheral port.
//
// Writes complete with zero wait states while the FIFO has room. The FIFO
// drains one entry per cycle whenever ReadyToWork is high. A read is held
// in wait states until every buffered write has drained, and only then is
// it issued to the external side.
//
// Optional feature macro: AHB_SLAVE_WBUF_ERR_EN
//   defined   : oversized HSIZE or StopOp at address phase -> two-cycle ERROR
//   undefined : HRESP tied low, oversized HSIZE is treated as full width,
//               StopOp is ignored
//
// Ports
//   HCLK, HRESETn          clock (rising edge), asynchronous active-low reset
//   HADDR..HWDATA          AHB-Lite slave inputs
//   HREADYOUT/HRESP/HRDATA AHB-Lite slave outputs
//   Write/Read             external write strobe / read request
//   AddressOUT/OutputData  external address / write data
//   ByteEnOUT              byte lane enables of the write being drained
//   FifoLevel              number of buffered writes
//   InData/ValidRead       external read data and its valid
//   StopOp                 back end refuses new requests
//   ReadyToWork            back end accepts a write this cycle
//   dbg_state              current FSM state (debug observation)
//
// Handshake: an AHB transfer is accepted on a rising edge where
// HSELx & HREADY & HTRANS[1]; a data phase completes on a rising edge where
// HREADYOUT is 1. The external write side is valid/ready: an entry leaves
// the FIFO on an edge where Write (valid) and ReadyToWork (ready) are both 1;
// Write is only raised when ReadyToWork is already high.
module ahb_slave_wbuf #(
  parameter int AddresseWidth = 32,
  parameter int DataWidth     = 32,
  parameter int FifoDepth     = 4
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  input  logic [AddresseWidth-1:0]        HADDR,
  input  logic                            HWRITE,
  input  logic [2:0]                      HSIZE,
  input  logic [2:0]                      HBURST,
  input  logic [1:0]                      HTRANS,
  input  logic                            HREADY,
  input  logic                            HSELx,
  input  logic [DataWidth-1:0]            HWDATA,
  output logic                            HREADYOUT,
  output logic                            HRESP,
  output logic [DataWidth-1:0]            HRDATA,
  output logic                            Write,
  output logic                            Read,
  output logic [AddresseWidth-1:0]        AddressOUT,
  output logic [DataWidth-1:0]            OutputData,
  output logic [DataWidth/8-1:0]          ByteEnOUT,
  output logic [$clog2(FifoDepth):0]      FifoLevel,
  input  logic [DataWidth-1:0]            InData,
  input  logic                            ValidRead,
  input  logic                            StopOp,
  input  logic                            ReadyToWork,
  output logic [2:0]                      dbg_state
);

  localparam int NB   = DataWidth / 8;
  localparam int LW   = $clog2(NB);
  localparam int PTRW = $clog2(FifoDepth);
  localparam int PW   = PTRW + 1;
  localparam logic [2:0]      MAX_SIZE = 3'(LW);
  localparam logic [PW-1:0]   FULL     = PW'(FifoDepth);
  localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WDATA = 3'd1,
    S_RWAIT = 3'd2,
    S_RREQ  = 3'd3,
    S_RDONE = 3'd4,
    S_ERR1  = 3'd5,
    S_ERR2  = 3'd6
  } state_t;

  state_t                   state;
  logic [AddresseWidth-1:0] a_addr;
  logic [NB-1:0]            a_be;

  logic [AddresseWidth-1:0] f_addr [FifoDepth];
  logic [DataWidth-1:0]     f_data [FifoDepth];
  logic [NB-1:0]            f_be   [FifoDepth];
  logic [PTRW-1:0]          wr_ptr, rd_ptr;
  logic [PW-1:0]            level;

  logic accept, req_err, push, pop;

  // Little-endian lane mask; sizes at or above the bus width select all lanes.
  function automatic logic [NB-1:0] lane_mask(input logic [2:0] size,
                                              input logic [LW-1:0] off);
    int nbytes;
    int start;
    if (size >= MAX_SIZE) return '1;
    nbytes = 1 << size;
    start  = int'(off) & ~(nbytes - 1);
    return NB'((1 << nbytes) - 1) << start;
  endfunction

  assign accept = HSELx & HREADY & HTRANS[1];

`ifdef AHB_SLAVE_WBUF_ERR_EN
  assign req_err = (HSIZE > MAX_SIZE) | StopOp;
  assign HRESP   = (state == S_ERR1) | (state == S_ERR2);
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HTRANS[0]};
`else
  assign req_err = 1'b0;
  assign HRESP   = 1'b0;
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HTRANS[0], StopOp};
`endif

  // Ready is decoded from registered state and the registered FIFO level, so
  // a pop in the same cycle as a full FIFO only frees the slot next cycle.
  always_comb begin
    HREADYOUT = 1'b1;
    case (state)
      S_WDATA:                 HREADYOUT = (level != FULL);
      S_RWAIT, S_RREQ, S_ERR1: HREADYOUT = 1'b0;
      default:                 HREADYOUT = 1'b1;
    endcase
  end

  assign push = (state == S_WDATA) && (level != FULL);
  assign pop  = (level != '0) && ReadyToWork;

  // A read is only requested with an empty FIFO, so Read and Write never
  // compete for AddressOUT.
  assign Write      = pop;
  assign Read       = (state == S_RREQ);
  assign AddressOUT = Read ? a_addr : (pop ? f_addr[rd_ptr] : '0);
  assign OutputData = pop ? f_data[rd_ptr] : '0;
  assign ByteEnOUT  = pop ? f_be[rd_ptr] : '0;
  assign FifoLevel  = level;
  assign dbg_state  = state;

  // Control FSM: a new transfer is taken only in a cycle that completes the
  // current data phase (HREADYOUT high), which chains pipelined transfers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= S_IDLE;
      a_addr <= '0;
      a_be   <= '0;
      HRDATA <= '0;
    end else begin
      case (state)
        S_RWAIT: if (level == '0) state <= S_RREQ;
        S_RREQ: begin
          if (ValidRead) begin
            HRDATA <= InData;
            state  <= S_RDONE;
          end
        end
        S_ERR1: state <= S_ERR2;
        default: begin
          if (HREADYOUT) begin
            if (accept) begin
              a_addr <= HADDR;
              a_be   <= lane_mask(HSIZE, HADDR[LW-1:0]);
              if (req_err)     state <= S_ERR1;
              else if (HWRITE) state <= S_WDATA;
              else             state <= S_RWAIT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  // FIFO bookkeeping; contents need no reset since level gates their use.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      level <= level + PW'(push) - PW'(pop);
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) begin
      f_addr[wr_ptr] <= a_addr;
      f_data[wr_ptr] <= HWDATA;
      f_be[wr_ptr]   <= a_be;
    end
  end

endmodule

// File: tb/tb_ahb_slave_wbuf.sv
// Testbench for ahb_slave_wbuf (32-bit bus, FifoDepth 4).
`timescale 1ns/1ps
module tb_ahb_slave_wbuf;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic        HSELx;
  logic [31:0] HWDATA;
  logic        HREADYOUT, HRESP;
  logic [31:0] HRDATA;
  logic        Write, Read;
  logic [31:0] AddressOUT, OutputData;
  logic [3:0]  ByteEnOUT;
  logic [2:0]  FifoLevel;
  logic [31:0] InData;
  logic        ValidRead, StopOp, ReadyToWork;
  logic [2:0]  dbg_state;

  // Single slave on the bus: the bus-wide ready is this slave's ready.
  assign HREADY = HREADYOUT;

  ahb_slave_wbuf #(.AddresseWidth(32), .DataWidth(32), .FifoDepth(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HREADY(HREADY),
    .HSELx(HSELx), .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA), .Write(Write), .Read(Read), .AddressOUT(AddressOUT),
    .OutputData(OutputData), .ByteEnOUT(ByteEnOUT), .FifoLevel(FifoLevel),
    .InData(InData), .ValidRead(ValidRead), .StopOp(StopOp),
    .ReadyToWork(ReadyToWork), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 HCLK = ~HCLK;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [67:0] exp_q[$];            // {addr, data, byte enables} in issue order
  logic [31:0] ref_mem[int];        // reference memory contents seen by the master
  logic [31:0] be_mem[int];         // back-end memory written by Write strobes
  bit          auto_be  = 1'b0;
  bit          rand_rtw = 1'b0;
  bit          dp_active = 1'b0;
  bit          dp_write  = 1'b0;
  logic [31:0] dp_exp;
  logic [67:0] mon_e;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [3:0]  exp_be;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction

  // ---------------- external-side monitor ----------------
  always @(negedge HCLK) begin
    if (HRESETn === 1'b1 && Write === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ext_write: got unexpected write %0h/%0h/%0h expected none",
                 AddressOUT, OutputData, ByteEnOUT);
      end else begin
        mon_e = exp_q.pop_front();
        if ({AddressOUT, OutputData, ByteEnOUT} !== mon_e) begin
          errors++;
          $display("FAIL ext_write: got %0h/%0h/%0h expected %0h/%0h/%0h",
                   AddressOUT, OutputData, ByteEnOUT, mon_e[67:36], mon_e[35:4], mon_e[3:0]);
        end
      end
      be_mem[int'(AddressOUT >> 2)] = merge(be_mem.exists(int'(AddressOUT >> 2)) ?
                                            be_mem[int'(AddressOUT >> 2)] : 32'h0,
                                            OutputData, ByteEnOUT);
    end
    if (HRESETn === 1'b1 && Read === 1'b1) chk("read_before_drain", FifoLevel, 0);
  end

  // ---------------- random back end ----------------
  always @(posedge HCLK) begin
    #2;
    if (auto_be) begin
      if (Read === 1'b1 && $urandom_range(0, 2) != 0) begin
        ValidRead = 1'b1;
        InData = be_mem.exists(int'(AddressOUT >> 2)) ? be_mem[int'(AddressOUT >> 2)] : 32'h0;
      end else begin
        ValidRead = 1'b0;
        InData = $urandom;
      end
    end
    if (rand_rtw) ReadyToWork = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge HCLK); #1;
  endtask

  // Waits for the edge that completes the current data phase, checking read
  // data in the completing cycle when the phase was a read.
  task automatic wait_ready();
    bit rdy;
    int n;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 100) begin
      @(negedge HCLK);
      rdy = HREADYOUT;
      if (rdy && dp_active && !dp_write) chk("read_data", HRDATA, dp_exp);
      @(posedge HCLK); #1;
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got HREADYOUT 0 for %0d cycles expected 1", n);
    end
    dp_active = 1'b0;
  endtask

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [2:0] size, input logic [3:0] be);
    int k;
    HSELx = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; HSIZE = size;
    wait_ready();
    HSELx = 1'b0; HTRANS = 2'b00;
    dp_active = 1'b1;
    dp_write  = wr;
    k = int'(addr >> 2);
    if (wr) begin
      HWDATA = data;
      exp_q.push_back({addr, data, be});
      ref_mem[k] = merge(ref_mem.exists(k) ? ref_mem[k] : 32'h0, data, be);
    end else begin
      dp_exp = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    end
  endtask

  task automatic idle_flush();
    HSELx = 1'b0; HTRANS = 2'b00;
    wait_ready();
  endtask

  task automatic addr_only(input bit wr, input logic [31:0] addr, input logic [2:0] size);
    HSELx = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; HSIZE = size;
  endtask

  task automatic go_idle();
    HSELx = 1'b0; HTRANS = 2'b00;
  endtask

  // ---------------- test sequence ----------------
  logic [31:0] d3[5];
  bit found;

  initial begin
    HRESETn = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd2; HBURST = 3'd0;
    HTRANS = 2'b00; HSELx = 1'b0; HWDATA = '0; InData = '0; ValidRead = 1'b0;
    StopOp = 1'b0; ReadyToWork = 1'b1;

    vecs[0] = '{32'h0000_0100, 3'd0, 32'h1111_1111, 4'b0001};
    vecs[1] = '{32'h0000_0101, 3'd0, 32'h2222_2222, 4'b0010};
    vecs[2] = '{32'h0000_0102, 3'd0, 32'h3333_3333, 4'b0100};
    vecs[3] = '{32'h0000_0103, 3'd0, 32'h4444_4444, 4'b1000};
    vecs[4] = '{32'h0000_0104, 3'd1, 32'h5555_5555, 4'b0011};
    vecs[5] = '{32'h0000_0106, 3'd1, 32'h6666_6666, 4'b1100};
    vecs[6] = '{32'h0000_0108, 3'd2, 32'h7777_7777, 4'b1111};
    vecs[7] = '{32'h0000_010B, 3'd1, 32'h8888_8888, 4'b1100};

    // Reset state
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    cyc(); cyc();
    @(negedge HCLK);
    chk("rst_hreadyout", HREADYOUT, 1);
    chk("rst_hresp", HRESP, 0);
    chk("rst_hrdata", HRDATA, 0);
    chk("rst_addressout", AddressOUT, 0);
    chk("rst_fifolevel", FifoLevel, 0);
    chk("rst_write", Write, 0);
    chk("rst_read", Read, 0);
    cyc();

    // Single zero-wait write, drained the following cycle
    addr_only(1'b1, 32'h0000_ABCD, 3'd2);
    exp_q.push_back({32'h0000_ABCD, 32'h0000_1234, 4'hF});
    cyc();
    go_idle(); HWDATA = 32'h0000_1234;
    @(negedge HCLK);
    chk("w1_zero_wait", HREADYOUT, 1);
    chk("w1_no_early_write", Write, 0);
    cyc();
    @(negedge HCLK);
    chk("w1_write", Write, 1);
    chk("w1_addr", AddressOUT, 32'h0000_ABCD);
    chk("w1_data", OutputData, 32'h0000_1234);
    chk("w1_be", ByteEnOUT, 4'hF);
    cyc();
    @(negedge HCLK);
    chk("w1_level_after", FifoLevel, 0);
    cyc();

    // Five back-to-back writes into a 4-deep FIFO with the back end stalled
    ReadyToWork = 1'b0;
    for (int i = 0; i < 5; i++) d3[i] = 32'hD000_0000 + 32'(i);
    for (int i = 0; i < 5; i++) begin
      HSELx = 1'b1; HTRANS = (i == 0) ? 2'b10 : 2'b11; HWRITE = 1'b1;
      HADDR = 32'h200 + 32'(4 * i); HSIZE = 3'd2;
      if (i > 0) HWDATA = d3[i-1];
      exp_q.push_back({32'h200 + 32'(4 * i), d3[i], 4'hF});
      cyc();
    end
    go_idle(); HWDATA = d3[4];
    @(negedge HCLK);
    chk("full_level", FifoLevel, 4);
    chk("full_wait", HREADYOUT, 0);
    cyc();
    @(negedge HCLK);
    chk("full_wait_hold", HREADYOUT, 0);
    cyc();
    ReadyToWork = 1'b1;
    @(negedge HCLK);
    chk("full_pop_write", Write, 1);
    chk("full_pop_still_wait", HREADYOUT, 0);
    cyc();
    @(negedge HCLK);
    chk("full_ready_after_pop", HREADYOUT, 1);
    chk("full_level_after_pop", FifoLevel, 3);
    repeat (6) cyc();
    @(negedge HCLK);
    chk("full_drained_q", exp_q.size(), 0);
    chk("full_drained_level", FifoLevel, 0);
    cyc();

    // Read held behind two buffered writes
    ReadyToWork = 1'b0;
    xfer(1'b1, 32'h300, 32'hAAAA_0300, 3'd2, 4'hF);
    xfer(1'b1, 32'h304, 32'hAAAA_0304, 3'd2, 4'hF);
    addr_only(1'b0, 32'h0000_ABCD, 3'd2);
    wait_ready();
    go_idle();
    @(negedge HCLK);
    chk("rd_wait_ready", HREADYOUT, 0);
    chk("rd_wait_no_read", Read, 0);
    chk("rd_wait_level", FifoLevel, 2);
    cyc(); cyc();
    ReadyToWork = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge HCLK);
      if (Read === 1'b1) found = 1'b1;
      else cyc();
    end
    chk("rd_issued", found, 1);
    if (found) begin
      chk("rd_writes_first", exp_q.size(), 0);
      chk("rd_addr", AddressOUT, 32'h0000_ABCD);
      ValidRead = 1'b1; InData = 32'h0000_5678;
      cyc();
      ValidRead = 1'b0;
      @(negedge HCLK);
      chk("rd_hrdata", HRDATA, 32'h0000_5678);
      chk("rd_done_ready", HREADYOUT, 1);
      chk("rd_done_okay", HRESP, 0);
    end
    cyc();

    // Error response / feature-disabled behaviour
`ifdef AHB_SLAVE_WBUF_ERR_EN
    addr_only(1'b1, 32'h400, 3'd3);
    cyc();
    go_idle();
    @(negedge HCLK);
    chk("err1_hresp", HRESP, 1);
    chk("err1_ready", HREADYOUT, 0);
    cyc();
    @(negedge HCLK);
    chk("err2_hresp", HRESP, 1);
    chk("err2_ready", HREADYOUT, 1);
    cyc();
    @(negedge HCLK);
    chk("err_level", FifoLevel, 0);
    chk("err_no_write", Write, 0);
    cyc();
    StopOp = 1'b1;
    addr_only(1'b0, 32'h404, 3'd2);
    cyc();
    go_idle(); StopOp = 1'b0;
    @(negedge HCLK);
    chk("stop_err1", {HRESP, HREADYOUT}, 2'b10);
    cyc();
    @(negedge HCLK);
    chk("stop_err2", {HRESP, HREADYOUT}, 2'b11);
    chk("stop_no_read", Read, 0);
    cyc();
`else
    addr_only(1'b1, 32'h400, 3'd3);
    exp_q.push_back({32'h400, 32'h0000_CAFE, 4'hF});
    cyc();
    go_idle(); HWDATA = 32'h0000_CAFE;
    @(negedge HCLK);
    chk("big_okay", HRESP, 0);
    chk("big_ready", HREADYOUT, 1);
    cyc();
    @(negedge HCLK);
    chk("big_write", Write, 1);
    chk("big_be", ByteEnOUT, 4'hF);
    cyc();
    StopOp = 1'b1;
    addr_only(1'b1, 32'h404, 3'd2);
    exp_q.push_back({32'h404, 32'h0000_BEEF, 4'hF});
    cyc();
    go_idle(); HWDATA = 32'h0000_BEEF; StopOp = 1'b0;
    @(negedge HCLK);
    chk("stop_ignored_okay", HRESP, 0);
    chk("stop_ignored_ready", HREADYOUT, 1);
    cyc(); cyc();
`endif

    // Reset while three writes are buffered and a read is waiting
    ReadyToWork = 1'b0;
    xfer(1'b1, 32'h500, 32'hBBBB_0500, 3'd2, 4'hF);
    xfer(1'b1, 32'h504, 32'hBBBB_0504, 3'd2, 4'hF);
    xfer(1'b1, 32'h508, 32'hBBBB_0508, 3'd2, 4'hF);
    addr_only(1'b0, 32'h50C, 3'd2);
    wait_ready();
    go_idle();
    @(negedge HCLK);
    chk("rst1_level_before", FifoLevel, 3);
    #1 HRESETn = 1'b0;
    exp_q.delete();
    #1;
    chk("rst1_level", FifoLevel, 0);
    chk("rst1_ready", HREADYOUT, 1);
    chk("rst1_read", Read, 0);
    cyc();
    HRESETn = 1'b1;
    cyc();

    // Reset while a read request is outstanding
    ReadyToWork = 1'b1;
    addr_only(1'b0, 32'h600, 3'd2);
    cyc();
    go_idle();
    cyc();
    @(negedge HCLK);
    chk("rst2_in_rreq", Read, 1);
    #1 HRESETn = 1'b0;
    #1;
    chk("rst2_read", Read, 0);
    chk("rst2_ready", HREADYOUT, 1);
    chk("rst2_addr", AddressOUT, 0);
    chk("rst2_level", FifoLevel, 0);
    cyc();
    HRESETn = 1'b1;
    cyc();

    // Table-driven byte-lane vectors
    for (int i = 0; i < 8; i++) begin
      xfer(1'b1, vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].exp_be);
      idle_flush();
      @(negedge HCLK);
      chk("vec_write", Write, 1);
      chk("vec_addr", AddressOUT, vecs[i].addr);
      chk("vec_data", OutputData, vecs[i].data);
      chk("vec_be", ByteEnOUT, vecs[i].exp_be);
      cyc();
    end

    // Randomized traffic against the reference memory
    auto_be  = 1'b1;
    rand_rtw = 1'b1;
    for (int i = 0; i < 150; i++) begin
      xfer(1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * $urandom_range(0, 7)),
           $urandom, 3'd2, 4'hF);
      if ($urandom_range(0, 3) == 0) idle_flush();
    end
    idle_flush();
    rand_rtw = 1'b0;
    ReadyToWork = 1'b1;
    repeat (10) cyc();
    @(negedge HCLK);
    chk("rand_drained_q", exp_q.size(), 0);
    chk("rand_drained_level", FifoLevel, 0);
    auto_be = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_slave_wbuf.md
# ahb_slave_wbuf

AHB-Lite slave with a posted-write buffer, for the same external memory/peripheral port as the existing AHB slave. Write data phases complete without waiting when a FIFO of configurable depth has room. Reads are held until all buffered writes have drained, and are then issued to the external side. Sizes wider than the bus, and requests arriving while the back end signals StopOp, get the two-cycle AHB ERROR response.

## Interface
- AddresseWidth, 32, HADDR/AddressOUT width
- DataWidth, 32, HWDATA/HRDATA/OutputData/InData width (32 or 64)
- FifoDepth, 4, posted-write entries (power of 2, ≥2)
- HCLK  in  1  clock, all logic rising-edge
- HRESETn  in  1  asynchronous active-low reset
- HADDR  in  AddresseWidth  address phase address
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HBURST  in  3  burst type (not decoded; AHB supplies each beat's address)
- HTRANS  in  2  IDLE 00, BUSY 01, NONSEQ 10, SEQ 11
- HREADY  in  1  bus-wide ready
- HSELx  in  1  slave select
- HWDATA  in  DataWidth  write data (data phase)
- HREADYOUT  out  1  slave ready; reset 1
- HRESP  out  1  1 = ERROR; reset 0
- HRDATA  out  DataWidth  read data; reset 0
- Write  out  1  external write strobe; reset 0
- Read  out  1  external read request; reset 0
- AddressOUT  out  AddresseWidth  external address; reset 0
- OutputData  out  DataWidth  external write data; reset 0
- ByteEnOUT  out  DataWidth/8  byte lane enables; reset 0
- FifoLevel  out  $clog2(FifoDepth)+1  buffered-write count; reset 0
- InData  in  DataWidth  external read data
- ValidRead  in  1  InData valid
- StopOp  in  1  back end refuses new requests
- ReadyToWork  in  1  back end can accept a write this cycle

## Operation
- Address phase is accepted when HSELx & HREADY & HTRANS[1]. IDLE/BUSY or unselected gets OKAY with zero wait. Address, HWRITE, HSIZE and byte lanes are registered.
- Byte lanes: HSIZE and HADDR[log2(DataWidth/8)-1:0] give the standard little-endian strobe. Full width = all ones.
- States:
  - IDLE: no data phase in progress.
  - WDATA: write data phase.
  - RWAIT: read waiting for the FIFO to become empty.
  - RREQ: Read asserted, waiting for ValidRead.
  - RDONE: read data returned.
  - ERR1, ERR2: two-cycle ERROR response.
- WDATA: HREADYOUT = (FifoLevel != FifoDepth), based on the registered level. When HREADYOUT=1, HWDATA, address and lanes are pushed at the clock edge. When full, wait states continue until an entry pops.
- Drain: when FIFO is non-empty and ReadyToWork=1, Write=1 for one cycle with the head entry on AddressOUT/OutputData/ByteEnOUT, and the head pops. Back-to-back pops are allowed.
- Read flow:
  - Read data phase enters RWAIT with HREADYOUT=0.
  - When FIFO is empty, go to RREQ: Read=1, AddressOUT = read address.
  - ValidRead=1 in RREQ: HRDATA <= InData, go to RDONE.
  - RDONE: HREADYOUT=1, HRESP=0, then IDLE (or the next data phase if a new transfer was accepted).
- Error: a transfer is errored if HSIZE > log2(DataWidth/8), or StopOp=1 at address phase.
  - ERR1: HRESP=1, HREADYOUT=0.
  - ERR2: HRESP=1, HREADYOUT=1.
  - Nothing is pushed or requested.
- Pipelining: a new address phase accepted during the last data-phase cycle (HREADYOUT=1) chains directly into its own data phase.

## Timing
- Write, FIFO not full: zero wait states. Entry is visible on Write no earlier than the cycle after the push.
- Read, FIFO empty, ValidRead in first RREQ cycle: data phase lasts 3 cycles (RWAIT, RREQ, RDONE).
- Simultaneous push and pop: FifoLevel unchanged. Pointers wrap modulo FifoDepth.
- Full FIFO with a pop in the same cycle: HREADYOUT stays 0 that cycle and goes 1 the next.
- StopOp only affects newly accepted address phases. Buffered writes still drain when ReadyToWork=1.
- HRESETn low at any point: all outputs go to their reset values immediately, FIFO contents are discarded, state returns to IDLE.

## Configuration
- AHB_SLAVE_WBUF_ERR_EN:
  - Defined: size and StopOp checks and the ERR1/ERR2 states are compiled in.
  - Undefined: HRESP is tied to 0, oversized HSIZE is treated as full width, and StopOp is ignored at address phase.

## Test plan
- Reset, HSELx=0, HTRANS=IDLE for 2 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0, AddressOUT=0, FifoLevel=0.
- NONSEQ write 0xABCD/0x1234, ReadyToWork=1 -> zero-wait data phase; next cycle Write=1, AddressOUT=0xABCD, OutputData=0x1234, ByteEnOUT=0xF.
- ReadyToWork=0, 5 back-to-back SEQ writes with FifoDepth=4 -> FifoLevel reaches 4, 5th data phase HREADYOUT=0; raise ReadyToWork -> one pop, then HREADYOUT=1 and all 5 drain in order.
- Two buffered writes, then read of 0xABCD -> Read stays 0 until both Writes complete; ValidRead with InData=0x5678 -> HRDATA=0x5678, HREADYOUT=1 in the RDONE cycle.
- With macro defined, HSIZE=3'b011 on a 32-bit bus (or StopOp=1) -> HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1; FifoLevel unchanged.
- HRESETn pulsed low while FifoLevel=3 and in RREQ -> Read=0, FifoLevel=0, HREADYOUT=1 immediately.
